// File: rtl/contador_configurable_pkg.sv
// Shared types and helpers for the configurable counter and its interface.
//   dir_e  : count direction (DIR_ABAJO = down, DIR_ARRIBA = up)
//   modo_e : limit behaviour (MODO_WRAP = wrap around, MODO_SAT = saturate)
//   calc_bits(max) : width needed to hold 0..max inclusive
package contador_pkg;

  typedef enum logic {
    DIR_ABAJO  = 1'b0,
    DIR_ARRIBA = 1'b1
  } dir_e;

  typedef enum logic {
    MODO_WRAP = 1'b0,
    MODO_SAT  = 1'b1
  } modo_e;

  // +1 so that max itself is representable
  function automatic int unsigned calc_bits(input int unsigned max);
    return (max >= 1) ? $clog2(max + 1) : 1;
  endfunction

endpackage

// File: rtl/contador_configurable_if.sv
// Control/status bundle of the configurable counter.
//   master : drives en, dir, modo_sat, load, valor_carga (and captura)
//   slave  : drives contador, tc, en_limite (and valor_capturado, capturado)
// Capture signals exist only when CONTADOR_CAPTURE_EN is defined.
interface contador_configurable_if #(
  parameter int unsigned N_BITS = 4
);

  logic              en;
  logic              dir;
  logic              modo_sat;
  logic              load;
  logic [N_BITS-1:0] valor_carga;
  logic [N_BITS-1:0] contador;
  logic              tc;
  logic              en_limite;
`ifdef CONTADOR_CAPTURE_EN
  logic              captura;
  logic [N_BITS-1:0] valor_capturado;
  logic              capturado;
`endif

  modport master (
    output en, dir, modo_sat, load, valor_carga,
`ifdef CONTADOR_CAPTURE_EN
    output captura,
    input  valor_capturado, capturado,
`endif
    input  contador, tc, en_limite
  );

  modport slave (
    input  en, dir, modo_sat, load, valor_carga,
`ifdef CONTADOR_CAPTURE_EN
    input  captura,
    output valor_capturado, capturado,
`endif
    output contador, tc, en_limite
  );

endinterface

// File: rtl/contador_configurable_divisor_tick.sv
// Enable-gated clock divider: tick every PRESCALE enabled cycles.
//   clk, reset (async, active low)
//   en   : advance the divider; en=0 freezes it
//   clr  : synchronous clear, wins over en
//   tick : combinational, high on the last enabled cycle of each period
// With PRESCALE=1 the internal count is constant 0 and tick reduces to en.
module divisor_tick #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;

  // divider count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/contador_configurable.sv
// Up/down counter with enable, synchronous load (clamped), wrap or saturate
// mode and built-in prescaler.
//   clk, reset (async, active low)
//   bus.en, bus.dir, bus.modo_sat, bus.load, bus.valor_carga : controls
//   bus.contador : registered count, 0..COUNTER_MAX
//   bus.tc       : registered one-cycle pulse after every step taken at a limit
//   bus.en_limite: combinational, contador equals the limit in the current dir
// Optional macro CONTADOR_CAPTURE_EN adds captura/valor_capturado/capturado.
module contador_configurable
  import contador_pkg::*;
#(
  parameter int unsigned COUNTER_MAX = 9,
  parameter int unsigned PRESCALE    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  contador_configurable_if.slave  bus
);

  localparam int unsigned N_BITS = calc_bits(COUNTER_MAX);
  localparam logic [N_BITS-1:0] MAX_V = N_BITS'(COUNTER_MAX);

  logic [N_BITS-1:0] contador_q, contador_d;
  logic              tc_q, tc_d;
  logic [N_BITS-1:0] limite_c;
  logic              subir_c;
  logic              saturar_c;
  logic              tick_c;

  divisor_tick #(
    .PRESCALE (PRESCALE)
  ) u_divisor (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .clr   (bus.load),
    .tick  (tick_c)
  );

  assign subir_c   = (dir_e'(bus.dir) == DIR_ARRIBA);
  assign saturar_c = (modo_e'(bus.modo_sat) == MODO_SAT);
  assign limite_c  = subir_c ? MAX_V : '0;

  // next count: load beats step, step beats hold
  always_comb begin
    contador_d = contador_q;
    tc_d       = 1'b0;
    if (bus.load) begin
      contador_d = (bus.valor_carga > MAX_V) ? MAX_V : bus.valor_carga;
    end else if (tick_c) begin
      if (contador_q != limite_c) begin
        contador_d = subir_c ? contador_q + N_BITS'(1) : contador_q - N_BITS'(1);
      end else begin
        tc_d = 1'b1;
        if (!saturar_c) begin
          contador_d = subir_c ? '0 : MAX_V;
        end
      end
    end
  end

  // count and terminal-count registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      contador_q <= '0;
      tc_q       <= 1'b0;
    end else begin
      contador_q <= contador_d;
      tc_q       <= tc_d;
    end
  end

  assign bus.contador  = contador_q;
  assign bus.tc        = tc_q;
  assign bus.en_limite = (contador_q == limite_c);

`ifdef CONTADOR_CAPTURE_EN
  logic [N_BITS-1:0] valor_capturado_q;
  logic              capturado_q;

  // snapshot of the pre-update count, independent of en/load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valor_capturado_q <= '0;
      capturado_q       <= 1'b0;
    end else begin
      capturado_q <= bus.captura;
      if (bus.captura) begin
        valor_capturado_q <= contador_q;
      end
    end
  end

  assign bus.valor_capturado = valor_capturado_q;
  assign bus.capturado       = capturado_q;
`endif

endmodule

// File: doc/contador_configurable.md
Name: contador_configurable

Overview:
- Parametrised successor of the team's generic wrap-around counter. Adds an up/down direction, a count enable, a synchronous load, a wrap or saturate mode, and a built-in prescaler.
- Emits a registered terminal-count pulse and a combinational at-limit flag.
- Used as the timebase and event counter for lab designs: display multiplexing, debounce windows, timers.

Parameters:
- COUNTER_MAX, 9, highest value reached (inclusive); must be >= 1.
- PRESCALE, 1, number of enabled clk cycles per count step; must be >= 1; 1 means a step every enabled cycle.
- N_BITS (localparam), $clog2(COUNTER_MAX+1), width of the count. The +1 is required so that COUNTER_MAX itself is representable.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- dir  input  1  direction: 1 = up, 0 = down.
- modo_sat  input  1  mode: 1 = saturate at limits, 0 = wrap.
- load  input  1  synchronous load strobe.
- valor_carga  input  N_BITS  value to load.
- contador  output  N_BITS  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- en_limite  output  1  combinational flag: high when contador equals MAX (dir=1) or 0 (dir=0).

Behaviour:
- Reset: reset low asynchronously forces contador=0, tc=0 and prescaler=0. Counting resumes on the first rising edge after reset is released high.
- Priority per edge, highest first: reset, then load, then step, then hold.
- Load:
  - load=1 sets contador to valor_carga, clamped to COUNTER_MAX if larger.
  - Clears the prescaler and sets tc=0.
  - load overrides en.
- Prescaler:
  - Internal count 0..PRESCALE-1; it advances only while en=1 and load=0.
  - tick=1 in the cycle the prescaler equals PRESCALE-1 and en=1; the prescaler then returns to 0.
  - en=0 freezes the prescaler; it does not clear it.
  - With PRESCALE=1, tick equals en.
- Step (tick=1), with limit L = COUNTER_MAX when dir=1 and 0 when dir=0:
  - contador != L: contador increments (dir=1) or decrements (dir=0) by 1.
  - contador == L and modo_sat=0: contador wraps to the opposite bound (MAX goes to 0, 0 goes to MAX); tc=1 on that edge.
  - contador == L and modo_sat=1: contador holds; tc=1 on that edge.
- tc timing:
  - tc is high for exactly one cycle following each terminal step, and is 0 otherwise.
  - Every tick taken at a limit in saturate mode re-asserts tc.
- Latency: contador and tc update 1 cycle after the qualifying edge. en_limite has zero latency.
- Mid-count changes: changing dir or modo_sat takes effect at the next step. There is no pipeline, so no state is lost.
- Arithmetic: all operations are N_BITS wide. Because of the clamp and wrap rules, contador never exceeds COUNTER_MAX.

Optional Feature:
- Macro: CONTADOR_CAPTURE_EN.
- When defined:
  - Adds input captura (1 bit), output valor_capturado (N_BITS) and output capturado (1 bit).
  - captura=1 registers the value of contador as it was before this edge's update.
  - capturado pulses for 1 cycle afterwards.
  - Reset clears both outputs to 0.
  - Capture is independent of en and load.
- When undefined: those ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package contador_pkg:
  - typedef enum logic {DIR_ABAJO=0, DIR_ARRIBA=1}.
  - typedef enum logic {MODO_WRAP=0, MODO_SAT=1}.
  - Function for the N_BITS width computation.
- Sub-module divisor_tick (parameter PRESCALE; ports clk, reset, en, clr; output tick):
  - Natural split; reused elsewhere for baud and refresh ticks.
  - When PRESCALE=1 it reduces to tick=en.

Test Plan (defaults COUNTER_MAX=9, PRESCALE=1 unless stated):
- Reset: hold reset low, then release; en=1, dir=1, modo_sat=0 for 12 cycles → contador 0,1,...,9,0,1. tc high for exactly the one cycle in which contador=0 after 9. en_limite high while contador=9.
- Down, saturate: load 2, then dir=0, modo_sat=1, en=1 for 5 cycles → 2,1,0,0,0. tc pulses once for each tick taken at 0.
- Load and clamp: valor_carga=15 with load=1 and en=1 → contador=9 (clamped). Next edge with load=0 → contador=0 (wrap), tc=1.
- Prescaler (PRESCALE=4): en=1 for 8 cycles → steps land on cycles 4 and 8 (contador=2). Drop en for 2 cycles mid-count → prescaler frozen; on re-enable the step lands 4 enabled cycles after the previous one.
- Async reset mid-count: assert reset low between clock edges at contador=5 → contador=0 and tc=0 immediately, without waiting for a clk edge.
- CONTADOR_CAPTURE_EN: captura=1 when contador=6 → next cycle valor_capturado=6 and capturado=1 for one cycle, while counting continues to 7.
